// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with explicit-select or round-robin grant and a registered output.
// Optional handshake counter (cnt_o, clr_cnt_i) enabled by defining STREAM_MUX_ARB_CNT_EN.
module stream_mux_arb #(
  parameter  int Width = 16,
  parameter  int NumCh = 4,
  localparam int SelW  = $clog2(NumCh)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCh*Width-1:0] x_i,
  input  logic [NumCh-1:0]       valid_i,
  output logic [NumCh-1:0]       ready_o,
  input  logic                   mode_i,
  input  logic [SelW-1:0]        sel_i,
  output logic [Width-1:0]       xn_o,
  output logic [SelW-1:0]        ch_o,
  output logic                   valid_o,
  input  logic                   ready_i
`ifdef STREAM_MUX_ARB_CNT_EN
  ,
  input  logic                   clr_cnt_i,
  output logic [31:0]            cnt_o
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [Width-1:0] xn_q, xn_d;
  logic [SelW-1:0]  ch_q, ch_d;
  logic [SelW-1:0]  last_q, last_d;

  logic [Width-1:0] x_ch [NumCh];
  logic [NumCh-1:0] grant;
  logic             gvld;
  logic [SelW-1:0]  gidx;
  logic [Width-1:0] gdata;
  int unsigned      rr_idx;
  logic             load;

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    assign x_ch[k] = x_i[k*Width +: Width];
  end

  // Round-robin scans downward from the farthest candidate so the closest
  // channel after last_q is the final (winning) assignment.
  always_comb begin
    gvld   = 1'b0;
    gidx   = '0;
    gdata  = '0;
    rr_idx = 0;
    if (!mode_i) begin
      for (int k = 0; k < NumCh; k++) begin
        if (sel_i == SelW'(k) && valid_i[k]) begin
          gvld  = 1'b1;
          gidx  = SelW'(k);
          gdata = x_ch[k];
        end
      end
    end else begin
      for (int i = NumCh; i >= 1; i--) begin
        rr_idx = (int'(last_q) + i) % NumCh;
        if (valid_i[rr_idx]) begin
          gvld  = 1'b1;
          gidx  = SelW'(rr_idx);
          gdata = x_ch[rr_idx];
        end
      end
    end
    for (int k = 0; k < NumCh; k++) grant[k] = gvld && (gidx == SelW'(k));
  end

  assign load    = (state_q == EMPTY) | (ready_i & (state_q == FULL));
  assign ready_o = (rst_ni && load) ? grant : '0;

  always_comb begin
    state_d = state_q;
    xn_d    = xn_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (load) begin
      if (gvld) begin
        state_d = FULL;
        xn_d    = gdata;
        ch_d    = gidx;
        if (mode_i) last_d = gidx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      xn_q    <= '0;
      ch_q    <= '0;
      last_q  <= SelW'(NumCh - 1);
    end else begin
      state_q <= state_d;
      xn_q    <= xn_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = (state_q == FULL);
  assign xn_o    = xn_q;
  assign ch_o    = ch_q;

`ifdef STREAM_MUX_ARB_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        hs;

  // Clear wins over the old count, but a same-cycle handshake still counts.
  assign hs = valid_o & ready_i;
  always_comb begin
    cnt_d = clr_cnt_i ? 32'd0 : cnt_q;
    if (hs) cnt_d = cnt_d + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized + directed bench for stream_mux_arb against a transfer-level reference model.
module tb_stream_mux_arb;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N*W-1:0] x;
  logic [N-1:0] valid, ready_o;
  logic         mode, rdy, vo;
  logic [1:0]   sel, ch;
  logic [W-1:0] xn;

  logic [3*W-1:0] x3;
  logic [2:0]   valid3, ready3;
  logic [1:0]   sel3, ch3;
  logic [W-1:0] xn3;
  logic         vo3;
  logic         clr;
`ifdef STREAM_MUX_ARB_CNT_EN
  logic [31:0]  cnt, cnt3;
`endif

  stream_mux_arb #(.Width(W), .NumCh(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .valid_i(valid), .ready_o(ready_o),
    .mode_i(mode), .sel_i(sel), .xn_o(xn), .ch_o(ch), .valid_o(vo), .ready_i(rdy)
`ifdef STREAM_MUX_ARB_CNT_EN
    , .clr_cnt_i(clr), .cnt_o(cnt)
`endif
  );

  stream_mux_arb #(.Width(W), .NumCh(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x3), .valid_i(valid3), .ready_o(ready3),
    .mode_i(1'b0), .sel_i(sel3), .xn_o(xn3), .ch_o(ch3), .valid_o(vo3), .ready_i(1'b1)
`ifdef STREAM_MUX_ARB_CNT_EN
    , .clr_cnt_i(clr), .cnt_o(cnt3)
`endif
  );

  int total = 0, bad = 0;

  // Reference model: the output slot, its contents, and the last RR winner.
  bit          m_vld;
  logic [W-1:0] m_data;
  int          m_ch, m_last;
  logic [31:0] m_cnt;

  function automatic int exp_grant();
    if (!mode) return valid[sel] ? int'(sel) : -1;
    for (int i = 1; i <= N; i++) begin
      int c = (m_last + i) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g = exp_grant();
    if (!rst_n || (m_vld && !rdy) || g < 0) return '0;
    return N'(1 << g);
  endfunction

  task automatic tick();
    int g = exp_grant();
    bit ld = !m_vld || rdy;
    bit hs = m_vld && rdy;
    @(posedge clk);
    if (!rst_n) begin
      m_vld = 0; m_data = '0; m_ch = 0; m_last = N - 1; m_cnt = 0;
    end else begin
      if (ld) begin
        if (g >= 0) begin
          m_vld = 1; m_data = x[g*W +: W]; m_ch = g;
          if (mode) m_last = g;
        end else m_vld = 0;
      end
      m_cnt = clr ? 32'(hs) : m_cnt + 32'(hs);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; valid = '1; mode = 1; rdy = 1; #1;
    total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready_o); end
    tick(); tick();
    total++; if (vo !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", vo); end
    total++; if (xn !== 16'h0) begin bad++; $display("FAIL reset_xn got=%h exp=0000", xn); end
    total++; if (ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", ch); end
    total++; if (vo3 !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", vo3); end
    rst_n = 1; valid = '0;
  endtask

  task automatic test_explicit();
    mode = 0; sel = 2; valid = 4'b0100; x = '0; x[2*W +: W] = 16'h1234; rdy = 1; #1;
    total++; if (ready_o !== 4'b0100) begin bad++; $display("FAIL sel2_ready got=%b exp=0100", ready_o); end
    tick();
    total++; if (vo !== 1'b1) begin bad++; $display("FAIL sel2_valid got=%b exp=1", vo); end
    total++; if (xn !== 16'h1234) begin bad++; $display("FAIL sel2_xn got=%h exp=1234", xn); end
    total++; if (ch !== 2'd2) begin bad++; $display("FAIL sel2_ch got=%0d exp=2", ch); end
    sel = 1; valid = 4'b1101; #1;
    total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL sel1_invalid_ready got=%b exp=0000", ready_o); end
    tick();
    total++; if (vo !== 1'b0) begin bad++; $display("FAIL sel1_invalid_valid got=%b exp=0", vo); end
    valid3 = 3'b111; sel3 = 3; x3 = {16'h3333, 16'h2222, 16'h1111}; #1;
    total++; if (ready3 !== 3'b000) begin bad++; $display("FAIL sel_oob_ready got=%b exp=000", ready3); end
    sel3 = 1; #1;
    total++; if (ready3 !== 3'b010) begin bad++; $display("FAIL sel3_inrange_ready got=%b exp=010", ready3); end
    tick();
    total++; if (xn3 !== 16'h2222 || ch3 !== 2'd1) begin bad++; $display("FAIL n3_load got=%h/%0d exp=2222/1", xn3, ch3); end
    valid3 = '0; valid = '0;
  endtask

  task automatic test_backpressure();
    mode = 0; sel = 0; valid = 4'b0001; x[0 +: W] = 16'hAAAA; rdy = 1;
    tick();
    total++; if (xn !== 16'hAAAA || vo !== 1'b1) begin bad++; $display("FAIL bp_fill got=%h/%b exp=aaaa/1", xn, vo); end
    rdy = 0; valid = 4'b1111; x[0 +: W] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, ready_o); end
      tick();
      total++; if (xn !== 16'hAAAA || vo !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=aaaa/1", i, xn, vo); end
    end
    rdy = 1; x[0 +: W] = 16'hBBBB; #1;
    total++; if (ready_o !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got=%b exp=0001", ready_o); end
    tick();
    total++; if (xn !== 16'hBBBB || vo !== 1'b1) begin bad++; $display("FAIL bp_release_load got=%h/%b exp=bbbb/1", xn, vo); end
    valid = '0;
  endtask

  task automatic test_round_robin();
    int s1 [6] = '{0, 1, 2, 3, 0, 1};
    int s2 [4] = '{1, 3, 1, 3};
    do_reset();
    mode = 1; valid = 4'b1111; rdy = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (vo !== 1'b1 || int'(ch) != s1[i]) begin bad++; $display("FAIL rr_all[%0d] got=%0d exp=%0d", i, ch, s1[i]); end
    end
    do_reset();
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (vo !== 1'b1 || int'(ch) != s2[i]) begin bad++; $display("FAIL rr_1010[%0d] got=%0d exp=%0d", i, ch, s2[i]); end
    end
    do_reset();
    valid = 4'b0100; tick();
    total++; if (ch !== 2'd2) begin bad++; $display("FAIL rr_gap_seed got=%0d exp=2", ch); end
    valid = 4'b0101; tick();
    total++; if (ch !== 2'd0) begin bad++; $display("FAIL rr_gap_wrap got=%0d exp=0", ch); end
    tick();
    total++; if (ch !== 2'd2) begin bad++; $display("FAIL rr_gap_next got=%0d exp=2", ch); end
    valid = '0;
  endtask

  task automatic test_reset_mid();
    mode = 0; sel = 0; valid = 4'b0001; x[0 +: W] = 16'hCAFE; rdy = 1; tick();
    rdy = 0; tick();
    total++; if (vo !== 1'b1 || xn !== 16'hCAFE) begin bad++; $display("FAIL mid_full got=%b/%h exp=1/cafe", vo, xn); end
    rst_n = 0; tick(); rst_n = 1;
    total++; if (vo !== 1'b0 || xn !== 16'h0) begin bad++; $display("FAIL mid_reset got=%b/%h exp=0/0000", vo, xn); end
    valid = '0;
  endtask

`ifdef STREAM_MUX_ARB_CNT_EN
  task automatic test_counter();
    do_reset();
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", cnt); end
    mode = 1; valid = 4'b1111; rdy = 1; clr = 0;
    repeat (11) tick();
    total++; if (cnt !== 32'd10) begin bad++; $display("FAIL cnt_10 got=%0d exp=10", cnt); end
    clr = 1; tick(); clr = 0;
    total++; if (cnt !== 32'd1) begin bad++; $display("FAIL cnt_clr_hs got=%0d exp=1", cnt); end
    valid = '0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      valid = N'($urandom);
      mode  = 1'($urandom);
      sel   = 2'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 19) == 0);
      x     = {$urandom, $urandom};
      #1;
      total++; if (ready_o !== exp_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, ready_o, exp_ready()); end
      tick();
      total++; if (vo !== m_vld || xn !== m_data || int'(ch) != m_ch) begin
        bad++; $display("FAIL rnd_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, vo, xn, ch, m_vld, m_data, m_ch);
      end
`ifdef STREAM_MUX_ARB_CNT_EN
      total++; if (cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, cnt, m_cnt); end
`endif
    end
    rst_n = 1; clr = 0; valid = '0;
  endtask

  initial begin
    rst_n = 0; x = '0; valid = '0; mode = 0; sel = 0; rdy = 0; clr = 0;
    x3 = '0; valid3 = '0; sel3 = 0;
    m_vld = 0; m_data = '0; m_ch = 0; m_last = N - 1; m_cnt = 0;
    test_reset();
    test_explicit();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
`ifdef STREAM_MUX_ARB_CNT_EN
    test_counter();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel successor to the 2:1 datapath mux.
- Selects one of NumCh valid/ready input streams and registers it onto a single output stream.
- Selection is either explicit (sel_i) or round-robin arbitration.
- Sits in front of the shared CORDIC iteration stage so several operand sources can share one core without losing samples.

Parameters:
- Width, 16, data width of each channel and of the output.
- NumCh, 4, number of input channels; legal range 2..16.
- SelW, $clog2(NumCh), width of sel_i and ch_o; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- x_i  input  NumCh*Width  packed channel data; channel k occupies bits [k*Width +: Width].
- valid_i  input  NumCh  per-channel valid.
- ready_o  output  NumCh  per-channel ready.
- mode_i  input  1  0 = explicit select, 1 = round-robin.
- sel_i  input  SelW  channel index, used only when mode_i=0.
- xn_o  output  Width  registered selected data.
- ch_o  output  SelW  index of the channel held in xn_o.
- valid_o  output  1  output valid.
- ready_i  input  1  downstream ready.

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - valid_o=0, xn_o=0, ch_o=0.
  - Round-robin pointer last_q=NumCh-1, so channel 0 has top priority after reset.
  - ready_o=0 combinationally while rst_ni=0.
- Output register FSM:
  - EMPTY: valid_o=0.
  - FULL: valid_o=1.
  - load = (state==EMPTY) | (ready_i & valid_o).
- Grant (combinational, from the current-cycle valid_i):
  - mode_i=0: grant channel sel_i if valid_i[sel_i]=1, else none.
  - mode_i=0 with sel_i >= NumCh: no grant, and ready_o is all zeros.
  - mode_i=1: grant the first channel with valid_i=1, searching from last_q+1 upward and wrapping modulo NumCh; last_q itself is searched last.
- ready_o[k] = load & grant[k]. At most one bit is high; ready_o never depends on valid_i of other channels except through arbitration.
- On a load with a grant:
  - xn_o <= x_i[g]; ch_o <= g; state -> FULL.
  - If mode_i=1, last_q <= g.
- On a load with no grant:
  - state -> EMPTY; xn_o and ch_o hold their previous values.
- No load (FULL & !ready_i):
  - All output registers hold, and valid_o stays high.
  - The output is stable until consumed (AXI-style: no withdraw, no change).
- Latency: 1 cycle from input handshake to valid_o. Throughput: 1 transfer/cycle when ready_i is held high.
- Simultaneous consume and load in the same cycle: the new word replaces the old word, and valid_o stays 1.
- last_q updates only on an accepted transfer in mode 1. A mode change does not reset last_q.
- mode_i and sel_i may change every cycle; they affect only the next load decision.
- Reset mid-transfer: a held word is discarded, and valid_o is 0 on the cycle after the reset edge.

Optional Feature:
- Macro: STREAM_MUX_ARB_CNT_EN.
- Defined:
  - Adds output port cnt_o [31:0]: the count of output handshakes (valid_o & ready_i).
  - Reset value 0; increments by 1 per handshake; wraps 0xFFFF_FFFF -> 0.
  - Adds input clr_cnt_i [1]: synchronous clear to 0.
  - If clear and a handshake occur in the same cycle, cnt_o becomes 1.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
1. Reset, then mode_i=0, sel_i=2, valid_i=4'b0100, x_i ch2=16'h1234, ready_i=1 -> ready_o=4'b0100; next cycle valid_o=1, xn_o=16'h1234, ch_o=2.
2. mode_i=0, sel_i=1, valid_i=4'b1101 -> ready_o=0, no load, valid_o=0. Repeat with sel_i=3 on a NumCh=3 build -> ready_o=0.
3. Backpressure: output FULL with xn_o=16'hAAAA, ready_i=0 for 5 cycles with all valid_i=1 -> ready_o=0, xn_o stays 16'hAAAA. Then ready_i=1 -> the next word loads in the same cycle, and valid_o stays 1.
4. Round-robin: mode_i=1, valid_i=4'b1111 held, ready_i=1 from reset -> ch_o sequence 0,1,2,3,0,1. With valid_i=4'b1010 -> 1,3,1,3.
5. Round-robin fairness across gaps: last grant ch2, then valid_i=4'b0101 -> next grant ch0, then ch2.
6. Reset asserted while FULL and ready_i=0 -> next cycle valid_o=0, xn_o=0. With STREAM_MUX_ARB_CNT_EN: 10 handshakes -> cnt_o=10; clr_cnt_i with a handshake in the same cycle -> cnt_o=1.
